// File: rtl/and_gate_1.sv
// Registered bitwise AND: s = a & b delayed by LATENCY flop stages; no comb path a/b -> s.
// Synchronous active-low reset clears every stage; the pipeline advances every cycle.
module and_gate_1 #(
  parameter int WIDTH   = 1,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s
);

  generate
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
      $error("and_gate_1: WIDTH must be in 1..64");
    end
    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
      $error("and_gate_1: LATENCY must be in 1..8");
    end
  endgenerate

  logic [WIDTH-1:0] stage [LATENCY];

  // Reset flushes all in-flight results so nothing stale emerges after release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= a & b;
      for (int k = 1; k < LATENCY; k++) begin
        stage[k] <= stage[k-1];
      end
    end
  end

  assign s = stage[LATENCY-1];

endmodule

// File: tb/tb_and_gate_1.sv
// Self-checking bench for and_gate_1: four parameterisations driven from one stimulus stream,
// compared against an edge-history reference model plus directed spot checks.
module tb_and_gate_1;

  logic        clk;
  logic        rst_n;
  logic [63:0] a_drv;
  logic [63:0] b_drv;
  logic        s_d0;
  logic        s_d1;
  logic [7:0]  s_d2;
  logic [63:0] s_d3;

  int tests_run = 0;
  int tests_failed = 0;

  logic [63:0] hist_a [$];
  logic [63:0] hist_b [$];
  bit          hist_r [$];

  initial clk = 1'b0;
  always #10 clk = ~clk;

  and_gate_1 #(.WIDTH(1), .LATENCY(1)) d0 (.clk(clk), .rst_n(rst_n), .a(a_drv[0]),    .b(b_drv[0]),    .s(s_d0));
  and_gate_1 #(.WIDTH(1), .LATENCY(3)) d1 (.clk(clk), .rst_n(rst_n), .a(a_drv[0]),    .b(b_drv[0]),    .s(s_d1));
  and_gate_1 #(.WIDTH(8), .LATENCY(4)) d2 (.clk(clk), .rst_n(rst_n), .a(a_drv[7:0]),  .b(b_drv[7:0]),  .s(s_d2));
  and_gate_1 #(.WIDTH(64), .LATENCY(8)) d3 (.clk(clk), .rst_n(rst_n), .a(a_drv),      .b(b_drv),       .s(s_d3));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output after edge k: zero if any reset edge lies in [k-L+1, k], else the AND sampled at k-L+1.
  function automatic logic [63:0] model(input int lat, input int w, input int k);
    logic [63:0] mask;
    int j;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    j = k - lat + 1;
    for (int i = (j < 0 ? 0 : j); i <= k; i++) begin
      if (!hist_r[i]) return 64'd0;
    end
    return (hist_a[j] & hist_b[j]) & mask;
  endfunction

  // Drive at the falling edge, record at the rising edge, check at the next falling edge.
  task automatic step(input bit r, input logic [63:0] av, input logic [63:0] bv);
    int k;
    rst_n = r;
    a_drv = av;
    b_drv = bv;
    @(posedge clk);
    hist_a.push_back(a_drv);
    hist_b.push_back(b_drv);
    hist_r.push_back(rst_n);
    k = hist_r.size() - 1;
    @(negedge clk);
    chk($sformatf("w1l1 e%0d", k), {63'd0, s_d0}, model(1, 1, k));
    chk($sformatf("w1l3 e%0d", k), {63'd0, s_d1}, model(3, 1, k));
    chk($sformatf("w8l4 e%0d", k), {56'd0, s_d2}, model(4, 8, k));
    chk($sformatf("w64l8 e%0d", k), s_d3, model(8, 64, k));
  endtask

  logic [63:0] ones;
  logic [3:0]  tt_a;
  logic [3:0]  tt_b;
  logic [4:0]  pulse_exp;

  initial begin
    ones = {64{1'b1}};
    rst_n = 1'b0;
    a_drv = ones;
    b_drv = ones;

    // Reset held 10 cycles with all-ones operands
    for (int i = 0; i < 10; i++) begin
      step(1'b0, ones, ones);
      chk("reset_s0", {63'd0, s_d0}, 64'd0);
      chk("reset_s3", s_d3, 64'd0);
    end

    // Truth table on the default instance
    tt_a = 4'b1100;
    tt_b = 4'b1010;
    for (int p = 0; p < 4; p++) begin
      step(1'b1, {64{tt_a[p]}}, {64{tt_b[p]}});
      chk($sformatf("truth %0d%0d", tt_a[p], tt_b[p]), {63'd0, s_d0}, {63'd0, tt_a[p] & tt_b[p]});
      step(1'b1, {64{tt_a[p]}}, {64{tt_b[p]}});
    end

    // Single-cycle pulse through the 3-stage instance
    for (int i = 0; i < 3; i++) step(1'b1, 64'd0, 64'd0);
    pulse_exp = 5'b00100;
    step(1'b1, ones, ones);
    chk("pulse e0", {63'd0, s_d1}, {63'd0, pulse_exp[0]});
    for (int i = 1; i < 5; i++) begin
      step(1'b1, 64'd0, 64'd0);
      chk($sformatf("pulse e%0d", i), {63'd0, s_d1}, {63'd0, pulse_exp[i]});
    end

    // Mid-stream reset on the 4-stage instance
    for (int i = 0; i < 5; i++) step(1'b1, ones, ones);
    chk("mid pre", {56'd0, s_d2}, 64'hFF);
    step(1'b0, ones, ones);
    chk("mid rst", {56'd0, s_d2}, 64'h00);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, ones, ones);
      chk($sformatf("mid hold%0d", i), {56'd0, s_d2}, 64'h00);
    end
    step(1'b1, ones, ones);
    chk("mid back", {56'd0, s_d2}, 64'hFF);

    // Wide operands
    for (int i = 0; i < 5; i++) step(1'b1, 64'hF0, 64'h3C);
    chk("wide f0&3c", {56'd0, s_d2}, 64'h30);
    for (int i = 0; i < 5; i++) step(1'b1, 64'hFF, 64'hA5);
    chk("wide ff&a5", {56'd0, s_d2}, 64'hA5);

    // Timed sequence: reset 200 ns, 1,0 for 100 ns, 1,1 for 100 ns, 0,0 for 2000 ns
    for (int i = 0; i < 10; i++) step(1'b0, 64'd1, 64'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 64'd1, 64'd0);
      chk("seq 10", {63'd0, s_d0}, 64'd0);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 64'd1, 64'd1);
      chk("seq 11", {63'd0, s_d0}, 64'd1);
    end
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 64'd0, 64'd0);
      chk("seq 00", {63'd0, s_d0}, 64'd0);
    end

    // Random traffic with occasional reset pulses
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 19) != 0),
           {$urandom, $urandom}, {$urandom, $urandom});
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
